// File: rtl/link_credit_rr_sched.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : link_credit_rr_sched                                          |
// | Purpose  : credit-gated round-robin scheduler onto one registered link   |
// |            beat stream, with enable/drain quiesce FSM.                   |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module link_credit_rr_sched #(
  parameter int NUM_REQ            = 4,
  parameter int WIDTH              = 64,
  parameter int CREDIT_MAX         = 32,
  parameter int LG_CREDIT_TO_TOKEN = 3
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               enable_i,
  input  logic [NUM_REQ-1:0]                 req_valid_i,
  input  logic [NUM_REQ*WIDTH-1:0]           req_data_i,
  output logic [NUM_REQ-1:0]                 req_ready_o,
  output logic                               link_valid_o,
  output logic [WIDTH-1:0]                   link_data_o,
  input  logic                               link_ready_i,
  input  logic                               token_i,
  output logic [$clog2(CREDIT_MAX+1)-1:0]    credit_o,
  output logic                               idle_o,
  output logic                               err_o
);

  localparam int                c_cw     = $clog2(CREDIT_MAX+1);
  localparam int                c_pw     = $clog2(NUM_REQ);
  localparam int                c_iw     = c_pw + 1;
  localparam logic [c_pw:0]     c_num    = c_iw'(NUM_REQ);
  localparam logic [c_pw-1:0]   c_last   = c_pw'(NUM_REQ-1);
  localparam logic [31:0]       c_token  = 32'(2**LG_CREDIT_TO_TOKEN);
  localparam logic [31:0]       c_cmax   = 32'(CREDIT_MAX);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_DRAIN  = 2'd2
  } state_t;

  state_t             r_state, w_state_nxt;
  logic [c_cw-1:0]    r_credit, w_credit_nxt;
  logic [c_pw-1:0]    r_ptr, w_gidx, w_ptr_nxt;
  logic [c_pw:0]      w_idx;
  logic               r_valid, r_err;
  logic [WIDTH-1:0]   r_data, w_gdata;
  logic               w_found, w_slot_free, w_grant_en, w_grant, w_ovf;
  logic [NUM_REQ-1:0] w_ready;
  logic [31:0]        w_sum;

  assign w_slot_free = !r_valid || link_ready_i;
  assign w_grant_en  = (r_state == ST_ACTIVE) && w_slot_free && (r_credit != '0);
  assign w_grant     = w_grant_en && w_found;

  // Round-robin search beginning at r_ptr, wrapping modulo NUM_REQ.
  always_comb begin
    w_found = 1'b0;
    w_gidx  = '0;
    w_idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_idx = {1'b0, r_ptr} + c_iw'(k);
      if (w_idx >= c_num) w_idx = w_idx - c_num;
      if (!w_found && req_valid_i[w_idx[c_pw-1:0]]) begin
        w_found = 1'b1;
        w_gidx  = w_idx[c_pw-1:0];
      end
    end
  end

  always_comb begin
    w_ready = '0;
    if (w_grant) w_ready[w_gidx] = 1'b1;
  end

  assign w_gdata   = req_data_i[w_gidx*WIDTH +: WIDTH];
  assign w_ptr_nxt = (w_gidx == c_last) ? '0 : w_gidx + 1'b1;

  // Token and grant in the same cycle net out; overflow saturates and flags.
  always_comb begin
    w_sum        = 32'(r_credit) + (token_i ? c_token : 32'd0) - (w_grant ? 32'd1 : 32'd0);
    w_ovf        = 1'b0;
    w_credit_nxt = w_sum[c_cw-1:0];
    if (w_sum > c_cmax) begin
      w_ovf        = 1'b1;
      w_credit_nxt = c_cw'(CREDIT_MAX);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (enable_i) w_state_nxt = ST_ACTIVE;
      ST_ACTIVE: if (!enable_i) w_state_nxt = ST_DRAIN;
      ST_DRAIN: begin
        if (enable_i)
          w_state_nxt = ST_ACTIVE;
        else if (!r_valid && (r_credit == c_cw'(CREDIT_MAX)))
          w_state_nxt = ST_IDLE;
      end
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_credit <= c_cw'(CREDIT_MAX);
      r_valid  <= 1'b0;
      r_data   <= '0;
      r_ptr    <= '0;
      r_err    <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_credit <= w_credit_nxt;
      if (w_ovf) r_err <= 1'b1;
      if (w_slot_free) begin
        r_valid <= w_grant;
        if (w_grant) r_data <= w_gdata;
      end
      if (w_grant) r_ptr <= w_ptr_nxt;
    end
  end

  assign req_ready_o  = w_ready;
  assign link_valid_o = r_valid;
  assign link_data_o  = r_data;
  assign credit_o     = r_credit;
  assign idle_o       = (r_state == ST_IDLE);
  assign err_o        = r_err;

endmodule
`default_nettype wire

// File: tb/tb_link_credit_rr_sched.sv
`default_nettype none
// Testbench for link_credit_rr_sched: directed scenarios plus random traffic,
// checked cycle by cycle against an integer reference model and a beat scoreboard.
module tb_link_credit_rr_sched;

  localparam int N    = 4;
  localparam int W    = 64;
  localparam int CMAX = 32;
  localparam int T    = 8;
  localparam int CW   = 6;

  logic           clk = 1'b0;
  logic           rst;
  logic           enable_i;
  logic [N-1:0]   req_valid_i;
  logic [N*W-1:0] req_data_i;
  logic [N-1:0]   req_ready_o;
  logic           link_valid_o;
  logic [W-1:0]   link_data_o;
  logic           link_ready_i;
  logic           token_i;
  logic [CW-1:0]  credit_o;
  logic           idle_o;
  logic           err_o;

  always #5 clk = ~clk;

  link_credit_rr_sched #(
    .NUM_REQ(N), .WIDTH(W), .CREDIT_MAX(CMAX), .LG_CREDIT_TO_TOKEN(3)
  ) dut (
    .clk(clk), .rst(rst), .enable_i(enable_i),
    .req_valid_i(req_valid_i), .req_data_i(req_data_i), .req_ready_o(req_ready_o),
    .link_valid_o(link_valid_o), .link_data_o(link_data_o), .link_ready_i(link_ready_i),
    .token_i(token_i), .credit_o(credit_o), .idle_o(idle_o), .err_o(err_o)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int dut_grants = 0;
  logic [W-1:0] exp_q[$];

  // Reference model: 0 idle, 1 active, 2 drain; credits as a plain integer.
  int m_state, m_credit, m_ptr, m_held, m_err;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state  = 0;
    m_credit = CMAX;
    m_ptr    = 0;
    m_held   = 0;
    m_err    = 0;
    exp_q.delete();
  endtask

  task automatic cycle(input logic e, input logic [N-1:0] v, input logic r,
                       input logic t, input logic rs);
    int g;
    int c;
    bit slot_free;
    logic [N-1:0] exp_rdy;
    @(negedge clk);
    rst = rs; enable_i = e; req_valid_i = v; link_ready_i = r; token_i = t;
    for (int i = 0; i < N; i++) req_data_i[i*W +: W] = {$urandom, $urandom};
    #1;
    slot_free = (m_held == 0) || r;
    g = -1;
    if (m_state == 1 && slot_free && m_credit > 0)
      for (int k = 0; k < N; k++)
        if (g < 0 && v[(m_ptr + k) % N]) g = (m_ptr + k) % N;
    exp_rdy = '0;
    if (g >= 0) exp_rdy[g] = 1'b1;
    if (req_ready_o != '0) dut_grants++;
    chk("req_ready", req_ready_o, exp_rdy);
    chk("link_valid", link_valid_o, m_held);
    chk("credit", credit_o, m_credit);
    chk("idle", idle_o, (m_state == 0));
    chk("err", err_o, m_err);
    if (rs) begin
      model_reset();
    end else begin
      case (m_state)
        0: if (e) m_state = 1;
        1: if (!e) m_state = 2;
        default: if (e) m_state = 1;
                 else if (m_held == 0 && m_credit == CMAX) m_state = 0;
      endcase
      if (slot_free) begin
        m_held = (g >= 0);
        if (g >= 0) exp_q.push_back(req_data_i[g*W +: W]);
      end
      if (g >= 0) m_ptr = (g + 1) % N;
      c = m_credit + (t ? T : 0) - ((g >= 0) ? 1 : 0);
      if (c > CMAX) begin c = CMAX; m_err = 1; end
      m_credit = c;
    end
  endtask

  // Monitor: every accepted beat must match the oldest expected beat.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (!rst && link_valid_o && link_ready_i) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL beat_unexpected: got %0h expected no beat at %0t", link_data_o, $time);
        end else begin
          chk("beat_data", link_data_o, exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic e;
    rst = 1'b1; enable_i = 1'b0; req_valid_i = '0; req_data_i = '0;
    link_ready_i = 1'b0; token_i = 1'b0;
    model_reset();
    repeat (2) cycle(1'b0, 4'h0, 1'b1, 1'b0, 1'b1);

    // Round robin over all requesters, then drain with a held beat.
    repeat (5) cycle(1'b1, 4'hF, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, 4'hF, 1'b0, 1'b0, 1'b0);
    chk("credit_after_4", credit_o, 28);
    cycle(1'b0, 4'hF, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 4'hF, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, 4'hF, 1'b1, 1'b1, 1'b0);
    chk("drain_not_idle", idle_o, 0);
    cycle(1'b0, 4'hF, 1'b1, 1'b0, 1'b0);
    chk("drain_credit_full", credit_o, 32);
    cycle(1'b0, 4'hF, 1'b1, 1'b0, 1'b0);
    chk("drain_to_idle", idle_o, 1);

    // Single requester exhausts credits, one token restores eight.
    cycle(1'b0, 4'h0, 1'b1, 1'b0, 1'b1);
    dut_grants = 0;
    repeat (37) cycle(1'b1, 4'b0100, 1'b1, 1'b0, 1'b0);
    chk("beats_32", dut_grants, 32);
    chk("credit_zero", credit_o, 0);
    chk("blocked_no_ready", req_ready_o, 0);
    dut_grants = 0;
    cycle(1'b1, 4'b0100, 1'b1, 1'b1, 1'b0);
    cycle(1'b1, 4'b0100, 1'b1, 1'b0, 1'b0);
    chk("credit_token", credit_o, 8);
    repeat (11) cycle(1'b1, 4'b0100, 1'b1, 1'b0, 1'b0);
    chk("beats_8", dut_grants, 8);

    // Backpressure holds the beat, release grants immediately.
    cycle(1'b0, 4'h0, 1'b1, 1'b0, 1'b1);
    repeat (2) cycle(1'b1, 4'hF, 1'b1, 1'b0, 1'b0);
    repeat (5) cycle(1'b1, 4'hF, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 4'hF, 1'b1, 1'b0, 1'b0);
    chk("grant_on_release", |req_ready_o, 1);

    // Credit arithmetic boundaries.
    cycle(1'b0, 4'h0, 1'b1, 1'b0, 1'b1);
    cycle(1'b1, 4'h0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 60 && m_credit != 10; i++) cycle(1'b1, 4'b0001, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 4'b0001, 1'b1, 1'b1, 1'b0);
    cycle(1'b1, 4'h0, 1'b1, 1'b0, 1'b0);
    chk("credit_net_17", credit_o, 17);
    for (int i = 0; i < 10 && m_credit != 14; i++) cycle(1'b1, 4'b0001, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 4'h0, 1'b1, 1'b1, 1'b0);
    cycle(1'b1, 4'h0, 1'b1, 1'b1, 1'b0);
    cycle(1'b1, 4'h0, 1'b1, 1'b1, 1'b0);
    chk("credit_30", credit_o, 30);
    chk("err_clear_30", err_o, 0);
    cycle(1'b1, 4'h0, 1'b1, 1'b0, 1'b0);
    chk("credit_sat", credit_o, 32);
    chk("err_sat", err_o, 1);

    // Reset mid-stream restarts arbitration at requester 0.
    repeat (6) cycle(1'b1, 4'hF, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 4'hF, 1'b1, 1'b0, 1'b1);
    cycle(1'b1, 4'hF, 1'b1, 1'b0, 1'b0);
    chk("rst_credit", credit_o, 32);
    chk("rst_valid", link_valid_o, 0);
    chk("rst_idle", idle_o, 1);
    chk("rst_err", err_o, 0);
    cycle(1'b1, 4'hF, 1'b1, 1'b0, 1'b0);
    chk("rst_rr_start", req_ready_o, 4'b0001);

    // Random traffic.
    e = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(63) == 0) e = ~e;
      cycle(e, 4'($urandom), ($urandom_range(3) != 0), ($urandom_range(5) == 0),
            ($urandom_range(399) == 0));
    end

    repeat (20) cycle(1'b0, 4'h0, 1'b1, 1'b1, 1'b0);
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
